// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  // Lowest bit of packed port slot 'port' when each slot is 'width' bits wide
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  // Number of registers addressable with 'addr_w' address bits
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue, cleared by write-back.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_dest,
  input  logic                     clr0_en,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1_en,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  // Decode this cycle's issue into a set mask and the write-backs into a clear mask
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en && !((ZERO_REG != 0) && (iss_dest == ZERO_ADDR)))
      set_vec[iss_dest] = 1'b1;
    if (clr0_en)
      clr_vec[clr0_addr] = 1'b1;
    if (clr1_en)
      clr_vec[clr1_addr] = 1'b1;
  end

  // Busy bits: a new producer (set) outranks a completing one (clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else
      busy <= set_vec | (busy & ~clr_vec);
  end

  // A register being written this cycle already shows its new data, so it reads not-busy
  for (genvar g = 0; g < NUM_RD; g++) begin : g_lookup
    logic [ADDR_W-1:0] a;
    assign a          = rd_addr[port_lo(g, ADDR_W) +: ADDR_W];
    assign rd_busy[g] = busy[a] & ~clr_vec[a];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: combinational bypassed reads, two prioritised write-back
// ports, optional hardwired zero register, busy scoreboard and a debug tap.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int DBG_IDX  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_dest,
  output logic                     wr_conflict,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] DBG_ADDR  = ADDR_W'(DBG_IDX);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic we0;
  logic we1;
  logic conflict_now;

  // Effective write enables: writes to the zero register are dropped, and reset
  // suppresses both the bypass and the scoreboard clears
  always_comb begin
    we0 = rst && wr0_en && !(ZERO_EN && (wr0_addr == ZERO_ADDR));
    we1 = rst && wr1_en && !(ZERO_EN && (wr1_addr == ZERO_ADDR));
    conflict_now = we0 && we1 && (wr0_addr == wr1_addr);
  end

  // Data array; port 1 is assigned last so a load beats an ALU result on the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (we0)
        mem[wr0_addr] <= wr0_data;
      if (we1)
        mem[wr1_addr] <= wr1_data;
    end
  end

  // Collision flag, one cycle after both ports hit the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wr_conflict <= 1'b0;
    else
      wr_conflict <= conflict_now;
  end

  // Read ports with write-through bypass: wr1, then wr0, then the array
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[port_lo(g, ADDR_W) +: ADDR_W];

    // Bypass selection for this read port
    always_comb begin
      if (ZERO_EN && (a == ZERO_ADDR))
        d = '0;
      else if (we1 && (wr1_addr == a))
        d = wr1_data;
      else if (we0 && (wr0_addr == a))
        d = wr0_data;
      else
        d = mem[a];
    end

    assign rd_data[port_lo(g, DATA_W) +: DATA_W] = d;
  end

  assign dbg_data = mem[DBG_ADDR];

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_en    (iss_en && rst),
    .iss_dest  (iss_dest),
    .clr0_en   (we0),
    .clr0_addr (wr0_addr),
    .clr1_en   (we1),
    .clr1_addr (wr1_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

endmodule
